arcade_input_mapper: RTL and testbench

- Parametrised keyboard/joystick-to-cabinet input mapper for 1–4 players, placed between hps_io (ps2_key, joystick_N) and the arcade core's control inputs.
- Replaces per-core ad-hoc key decoding with a registered block that provides:
  - fixed MAME/JPAC key map per player;
  - four-way rotation compensation;
  - coin pulse stretching;
  - a pause toggle;
  - keyboard-state clear on focus loss.

---
 rtl/arcade_input_mapper.sv | 320 ++++++++++++++++++++++++++++++++
 tb/tb_arcade_input_mapper.sv | 379 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/arcade_input_mapper.sv
// -----------------------------------------------------------------------------
// arcade_input_mapper
//
// Maps hps_io keyboard events and joystick words onto the control inputs of an
// arcade core for 1..4 players. Every output is registered and reflects an
// input one clock after that input is sampled.
//
// Parameters
//   NUM_PLAYERS       number of player channels (1..4)
//   COIN_PULSE_CYCLES coin output high time in clk_sys cycles (>= 1)
//   AUTOFIRE_DIV      autofire half-period in clk_sys cycles (>= 1)
//
// Ports
//   clk_sys    in   system clock
//   reset_n    in   asynchronous active-low reset
//   ps2_key    in   [10] toggles per event, [9] pressed, [8] extended, [7:0] code
//   joy        in   16 bits per player: [0]R [1]L [2]D [3]U [4]fire1 [5]fire2
//                   [6]start [7]coin [8]pause
//   rotate     in   0 none, 1 CCW-comp, 2 CW-comp, 3 180 degrees
//   focus_clr  in   synchronous clear of every held keyboard state
//   autofire   in   per-player autofire enable (only with ARCADE_INPUT_AUTOFIRE_EN)
//   up/down/left/right out  rotated directions, one bit per player
//   fire1/fire2/start  out  buttons, one bit per player
//   coin       out  stretched coin pulses, one bit per player
//   service    out  service switch (key 46)
//   pause      out  pause latch
//
// Optional feature macro: ARCADE_INPUT_AUTOFIRE_EN (adds the autofire port and
// square-wave gating of fire1). Without it fire1 is the plain merged source.
// -----------------------------------------------------------------------------
module arcade_input_mapper #(
    parameter int NUM_PLAYERS       = 2,
    parameter int COIN_PULSE_CYCLES = 1200000,
    parameter int AUTOFIRE_DIV      = 600000
) (
    input  logic                     clk_sys,
    input  logic                     reset_n,
    input  logic [10:0]              ps2_key,
    input  logic [16*NUM_PLAYERS-1:0] joy,
    input  logic [1:0]               rotate,
    input  logic                     focus_clr,
`ifdef ARCADE_INPUT_AUTOFIRE_EN
    input  logic [NUM_PLAYERS-1:0]   autofire,
`endif
    output logic [NUM_PLAYERS-1:0]   up,
    output logic [NUM_PLAYERS-1:0]   down,
    output logic [NUM_PLAYERS-1:0]   left,
    output logic [NUM_PLAYERS-1:0]   right,
    output logic [NUM_PLAYERS-1:0]   fire1,
    output logic [NUM_PLAYERS-1:0]   fire2,
    output logic [NUM_PLAYERS-1:0]   start,
    output logic [NUM_PLAYERS-1:0]   coin,
    output logic                     service,
    output logic                     pause
);

    if (NUM_PLAYERS < 1 || NUM_PLAYERS > 4 || COIN_PULSE_CYCLES < 1 || AUTOFIRE_DIV < 1) begin : g_bad_params
        $error("arcade_input_mapper: illegal parameter value");
    end

    localparam int CW = (COIN_PULSE_CYCLES > 1) ? $clog2(COIN_PULSE_CYCLES) : 1;

    // One state bit per physical key. Keys sharing a function (Ctrl/Space,
    // Start/F-key) keep separate bits so releasing one does not drop the other.
    localparam int K_P1_U   = 0,  K_P1_D = 1,  K_P1_L = 2,  K_P1_R = 3;
    localparam int K_P1_F1A = 4,  K_P1_F1B = 5, K_P1_F2 = 6;
    localparam int K_P2_U   = 7,  K_P2_D = 8,  K_P2_L = 9,  K_P2_R = 10;
    localparam int K_P2_F1  = 11, K_P2_F2 = 12;
    localparam int K_P3_U   = 13, K_P3_D = 14, K_P3_L = 15, K_P3_R = 16;
    localparam int K_P3_F1  = 17, K_P3_F2 = 18;
    localparam int K_P4_U   = 19, K_P4_D = 20, K_P4_L = 21, K_P4_R = 22;
    localparam int K_P4_F1  = 23, K_P4_F2 = 24;
    localparam int K_ST1    = 25, K_ST2 = 26, K_ST3 = 27, K_ST4 = 28;
    localparam int K_FK1    = 29, K_FK2 = 30;
    localparam int K_CO1    = 31, K_CO2 = 32, K_CO3 = 33, K_CO4 = 34;
    localparam int K_SVC    = 35, K_PAUSE = 36;
    localparam int NK       = 37;

    logic          r_toggle;
    logic [NK-1:0] r_keys;
    logic [NK-1:0] w_hit;
    logic [NK-1:0] w_keys_next;
    logic          w_event;
    logic          w_ext;

    assign w_event = ps2_key[10] ^ r_toggle;
    assign w_ext   = ps2_key[8];

    // Scancode decoder; arrows and numpad share codes and split on the
    // extended flag, everything else ignores it.
    always_comb begin
        w_hit = '0;
        case (ps2_key[7:0])
            8'h75: if (w_ext) w_hit[K_P1_U] = 1'b1; else w_hit[K_P4_U] = 1'b1;
            8'h72: if (w_ext) w_hit[K_P1_D] = 1'b1; else w_hit[K_P4_D] = 1'b1;
            8'h6B: if (w_ext) w_hit[K_P1_L] = 1'b1; else w_hit[K_P4_L] = 1'b1;
            8'h74: if (w_ext) w_hit[K_P1_R] = 1'b1; else w_hit[K_P4_R] = 1'b1;
            8'h14: w_hit[K_P1_F1A] = 1'b1;
            8'h29: w_hit[K_P1_F1B] = 1'b1;
            8'h11: w_hit[K_P1_F2]  = 1'b1;
            8'h2D: w_hit[K_P2_U]   = 1'b1;
            8'h2B: w_hit[K_P2_D]   = 1'b1;
            8'h23: w_hit[K_P2_L]   = 1'b1;
            8'h34: w_hit[K_P2_R]   = 1'b1;
            8'h1C: w_hit[K_P2_F1]  = 1'b1;
            8'h1B: w_hit[K_P2_F2]  = 1'b1;
            8'h43: w_hit[K_P3_U]   = 1'b1;
            8'h42: w_hit[K_P3_D]   = 1'b1;
            8'h3B: w_hit[K_P3_L]   = 1'b1;
            8'h4B: w_hit[K_P3_R]   = 1'b1;
            8'h35: w_hit[K_P3_F1]  = 1'b1;
            8'h3C: w_hit[K_P3_F2]  = 1'b1;
            8'h70: if (!w_ext) w_hit[K_P4_F1] = 1'b1;
            8'h71: if (!w_ext) w_hit[K_P4_F2] = 1'b1;
            8'h16: w_hit[K_ST1]    = 1'b1;
            8'h1E: w_hit[K_ST2]    = 1'b1;
            8'h26: w_hit[K_ST3]    = 1'b1;
            8'h25: w_hit[K_ST4]    = 1'b1;
            8'h05: w_hit[K_FK1]    = 1'b1;
            8'h06: w_hit[K_FK2]    = 1'b1;
            8'h2E: w_hit[K_CO1]    = 1'b1;
            8'h36: w_hit[K_CO2]    = 1'b1;
            8'h3D: w_hit[K_CO3]    = 1'b1;
            8'h3E: w_hit[K_CO4]    = 1'b1;
            8'h46: w_hit[K_SVC]    = 1'b1;
            8'h4D: w_hit[K_PAUSE]  = 1'b1;
            default: ;
        endcase
    end

    // Next key state feeds the output registers directly so a key event shows
    // on the outputs one clock after it is sampled. focus_clr wins over events.
    always_comb begin
        w_keys_next = r_keys;
        if (focus_clr) begin
            w_keys_next = '0;
        end else if (w_event) begin
            for (int i = 0; i < NK; i++) begin
                if (w_hit[i]) w_keys_next[i] = ps2_key[9];
            end
        end
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            r_toggle <= 1'b0;
            r_keys   <= '0;
        end else begin
            r_toggle <= ps2_key[10];
            r_keys   <= w_keys_next;
        end
    end

    // Keyboard contribution per player, index = player number.
    logic [3:0] w_k_up, w_k_down, w_k_left, w_k_right;
    logic [3:0] w_k_f1, w_k_f2, w_k_start, w_k_coin;

    assign w_k_up    = {w_keys_next[K_P4_U], w_keys_next[K_P3_U], w_keys_next[K_P2_U], w_keys_next[K_P1_U]};
    assign w_k_down  = {w_keys_next[K_P4_D], w_keys_next[K_P3_D], w_keys_next[K_P2_D], w_keys_next[K_P1_D]};
    assign w_k_left  = {w_keys_next[K_P4_L], w_keys_next[K_P3_L], w_keys_next[K_P2_L], w_keys_next[K_P1_L]};
    assign w_k_right = {w_keys_next[K_P4_R], w_keys_next[K_P3_R], w_keys_next[K_P2_R], w_keys_next[K_P1_R]};
    assign w_k_f1    = {w_keys_next[K_P4_F1], w_keys_next[K_P3_F1], w_keys_next[K_P2_F1],
                        w_keys_next[K_P1_F1A] | w_keys_next[K_P1_F1B]};
    assign w_k_f2    = {w_keys_next[K_P4_F2], w_keys_next[K_P3_F2], w_keys_next[K_P2_F2], w_keys_next[K_P1_F2]};
    assign w_k_start = {w_keys_next[K_ST4], w_keys_next[K_ST3],
                        w_keys_next[K_ST2] | w_keys_next[K_FK2],
                        w_keys_next[K_ST1] | w_keys_next[K_FK1]};
    assign w_k_coin  = {w_keys_next[K_CO4], w_keys_next[K_CO3], w_keys_next[K_CO2], w_keys_next[K_CO1]};

    // Players beyond NUM_PLAYERS and spare joystick bits are dropped here.
    logic w_unused_bits;
    assign w_unused_bits = ^{joy, w_k_up, w_k_down, w_k_left, w_k_right,
                             w_k_f1, w_k_f2, w_k_start, w_k_coin};

    logic [NUM_PLAYERS-1:0] w_src_u, w_src_d, w_src_l, w_src_r;
    logic [NUM_PLAYERS-1:0] w_src_f1, w_src_f2, w_src_st, w_src_co;
    logic                   w_pause_src;

    always_comb begin
        w_pause_src = w_keys_next[K_PAUSE];
        for (int p = 0; p < NUM_PLAYERS; p++) begin
            w_src_r[p]  = w_k_right[p] | joy[16*p+0];
            w_src_l[p]  = w_k_left[p]  | joy[16*p+1];
            w_src_d[p]  = w_k_down[p]  | joy[16*p+2];
            w_src_u[p]  = w_k_up[p]    | joy[16*p+3];
            w_src_f1[p] = w_k_f1[p]    | joy[16*p+4];
            w_src_f2[p] = w_k_f2[p]    | joy[16*p+5];
            w_src_st[p] = w_k_start[p] | joy[16*p+6];
            w_src_co[p] = w_k_coin[p]  | joy[16*p+7];
            w_pause_src = w_pause_src  | joy[16*p+8];
        end
    end

    // Rotation compensation; opposing directions are passed through untouched.
    logic [NUM_PLAYERS-1:0] w_rot_u, w_rot_d, w_rot_l, w_rot_r;

    always_comb begin
        w_rot_u = w_src_u;
        w_rot_d = w_src_d;
        w_rot_l = w_src_l;
        w_rot_r = w_src_r;
        case (rotate)
            2'd1: begin
                w_rot_u = w_src_l; w_rot_d = w_src_r; w_rot_l = w_src_d; w_rot_r = w_src_u;
            end
            2'd2: begin
                w_rot_u = w_src_r; w_rot_d = w_src_l; w_rot_l = w_src_u; w_rot_r = w_src_d;
            end
            2'd3: begin
                w_rot_u = w_src_d; w_rot_d = w_src_u; w_rot_l = w_src_r; w_rot_r = w_src_l;
            end
            default: ;
        endcase
    end

    logic [NUM_PLAYERS-1:0] w_fire1_out;

`ifdef ARCADE_INPUT_AUTOFIRE_EN
    localparam int AW = (AUTOFIRE_DIV > 1) ? $clog2(AUTOFIRE_DIV) : 1;

    logic [NUM_PLAYERS-1:0] r_f1_src_q;
    logic [NUM_PLAYERS-1:0] r_af_phase;
    logic [NUM_PLAYERS-1:0] w_af_phase_next;
    logic [AW-1:0]          r_af_cnt      [NUM_PLAYERS];
    logic [AW-1:0]          w_af_cnt_next [NUM_PLAYERS];

    // Square wave restarts high on each new press so the first shot is
    // immediate; it only advances while the fire source is held.
    always_comb begin
        for (int p = 0; p < NUM_PLAYERS; p++) begin
            w_af_phase_next[p] = r_af_phase[p];
            w_af_cnt_next[p]   = r_af_cnt[p];
            if (w_src_f1[p] && !r_f1_src_q[p]) begin
                w_af_phase_next[p] = 1'b1;
                w_af_cnt_next[p]   = AW'(AUTOFIRE_DIV - 1);
            end else if (w_src_f1[p]) begin
                if (r_af_cnt[p] == '0) begin
                    w_af_phase_next[p] = ~r_af_phase[p];
                    w_af_cnt_next[p]   = AW'(AUTOFIRE_DIV - 1);
                end else begin
                    w_af_cnt_next[p]   = r_af_cnt[p] - AW'(1);
                end
            end
            w_fire1_out[p] = w_src_f1[p] & (~autofire[p] | w_af_phase_next[p]);
        end
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            r_f1_src_q <= '0;
            r_af_phase <= '0;
            for (int p = 0; p < NUM_PLAYERS; p++) r_af_cnt[p] <= '0;
        end else begin
            r_f1_src_q <= w_src_f1;
            r_af_phase <= w_af_phase_next;
            for (int p = 0; p < NUM_PLAYERS; p++) r_af_cnt[p] <= w_af_cnt_next[p];
        end
    end
`else
    assign w_fire1_out = w_src_f1;
`endif

    logic [NUM_PLAYERS-1:0] r_up, r_down, r_left, r_right;
    logic [NUM_PLAYERS-1:0] r_fire1, r_fire2, r_start;
    logic [NUM_PLAYERS-1:0] r_coin, r_coin_src_q;
    logic [CW-1:0]          r_coin_cnt [NUM_PLAYERS];
    logic                   r_service, r_pause, r_pause_src_q;

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            r_up          <= '0;
            r_down        <= '0;
            r_left        <= '0;
            r_right       <= '0;
            r_fire1       <= '0;
            r_fire2       <= '0;
            r_start       <= '0;
            r_coin        <= '0;
            r_coin_src_q  <= '0;
            r_service     <= 1'b0;
            r_pause       <= 1'b0;
            r_pause_src_q <= 1'b0;
            for (int p = 0; p < NUM_PLAYERS; p++) r_coin_cnt[p] <= '0;
        end else begin
            r_up          <= w_rot_u;
            r_down        <= w_rot_d;
            r_left        <= w_rot_l;
            r_right       <= w_rot_r;
            r_fire1       <= w_fire1_out;
            r_fire2       <= w_src_f2;
            r_start       <= w_src_st;
            r_service     <= w_keys_next[K_SVC];
            r_pause_src_q <= w_pause_src;
            r_pause       <= r_pause ^ (w_pause_src & ~r_pause_src_q);
            r_coin_src_q  <= w_src_co;
            // A pulse runs COIN_PULSE_CYCLES clocks; edges during it are lost.
            for (int p = 0; p < NUM_PLAYERS; p++) begin
                if (r_coin[p]) begin
                    if (r_coin_cnt[p] == '0) r_coin[p] <= 1'b0;
                    else                     r_coin_cnt[p] <= r_coin_cnt[p] - CW'(1);
                end else if (w_src_co[p] && !r_coin_src_q[p]) begin
                    r_coin[p]     <= 1'b1;
                    r_coin_cnt[p] <= CW'(COIN_PULSE_CYCLES - 1);
                end
            end
        end
    end

    assign up      = r_up;
    assign down    = r_down;
    assign left    = r_left;
    assign right   = r_right;
    assign fire1   = r_fire1;
    assign fire2   = r_fire2;
    assign start   = r_start;
    assign coin    = r_coin;
    assign service = r_service;
    assign pause   = r_pause;

endmodule

// File: tb/tb_arcade_input_mapper.sv
module tb_arcade_input_mapper;

  localparam int NP = 4;
  localparam int CP = 5;
  localparam int AD = 4;

  logic        clk_sys = 1'b0;
  logic        reset_n = 1'b0;
  logic [10:0] ps2_key;
  logic [63:0] joy;
  logic [1:0]  rotate;
  logic        focus_clr;
`ifdef ARCADE_INPUT_AUTOFIRE_EN
  logic [3:0]  autofire;
`endif
  logic [3:0]  up, down, left, right, fire1, fire2, start, coin;
  logic        service, pause;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk_sys = ~clk_sys;

  arcade_input_mapper #(
    .NUM_PLAYERS(NP), .COIN_PULSE_CYCLES(CP), .AUTOFIRE_DIV(AD)
  ) dut (
    .clk_sys(clk_sys), .reset_n(reset_n), .ps2_key(ps2_key), .joy(joy),
    .rotate(rotate), .focus_clr(focus_clr),
`ifdef ARCADE_INPUT_AUTOFIRE_EN
    .autofire(autofire),
`endif
    .up(up), .down(down), .left(left), .right(right),
    .fire1(fire1), .fire2(fire2), .start(start), .coin(coin),
    .service(service), .pause(pause)
  );

  // ---------------- reference model ----------------
  bit          m_held [0:1][0:255];
  bit          m_tog;
  int          m_coin_rem [4];
  bit          m_coin_prev [4];
  bit          m_pause, m_pause_prev;
  int          m_af_k [4];
  bit          m_f1_prev [4];
  logic [33:0] m_out;

  function automatic bit ext_ignored(input logic [7:0] c);
    case (c)
      8'h75, 8'h72, 8'h6B, 8'h74, 8'h70, 8'h71: return 1'b0;
      default: return 1'b1;
    endcase
  endfunction

  task automatic model_reset();
    for (int e = 0; e < 2; e++) for (int c = 0; c < 256; c++) m_held[e][c] = 1'b0;
    m_tog = 1'b0; m_pause = 1'b0; m_pause_prev = 1'b0;
    for (int p = 0; p < 4; p++) begin
      m_coin_rem[p] = 0; m_coin_prev[p] = 1'b0; m_af_k[p] = 0; m_f1_prev[p] = 1'b0;
    end
    m_out = '0;
  endtask

  task automatic model_step();
    bit ev, e, psrc;
    logic [7:0] c;
    logic [3:0] ku, kd, kl, kr, kf1, kf2, kst, kco;
    logic [3:0] su, sd, sl, sr, f1, f2, st, co, ru, rd, rl, rr, f1o, coo;
    ev = (ps2_key[10] != m_tog);
    m_tog = ps2_key[10];
    if (focus_clr) begin
      for (int x = 0; x < 2; x++) for (int y = 0; y < 256; y++) m_held[x][y] = 1'b0;
    end else if (ev) begin
      c = ps2_key[7:0];
      e = ext_ignored(c) ? 1'b0 : ps2_key[8];
      m_held[e][c] = ps2_key[9];
    end
    ku  = {m_held[0][8'h75], m_held[0][8'h43], m_held[0][8'h2D], m_held[1][8'h75]};
    kd  = {m_held[0][8'h72], m_held[0][8'h42], m_held[0][8'h2B], m_held[1][8'h72]};
    kl  = {m_held[0][8'h6B], m_held[0][8'h3B], m_held[0][8'h23], m_held[1][8'h6B]};
    kr  = {m_held[0][8'h74], m_held[0][8'h4B], m_held[0][8'h34], m_held[1][8'h74]};
    kf1 = {m_held[0][8'h70], m_held[0][8'h35], m_held[0][8'h1C], m_held[0][8'h14] | m_held[0][8'h29]};
    kf2 = {m_held[0][8'h71], m_held[0][8'h3C], m_held[0][8'h1B], m_held[0][8'h11]};
    kst = {m_held[0][8'h25], m_held[0][8'h26], m_held[0][8'h1E] | m_held[0][8'h06],
           m_held[0][8'h16] | m_held[0][8'h05]};
    kco = {m_held[0][8'h3E], m_held[0][8'h3D], m_held[0][8'h36], m_held[0][8'h2E]};
    psrc = m_held[0][8'h4D];
    for (int p = 0; p < 4; p++) begin
      sr[p] = kr[p]  | joy[16*p+0];
      sl[p] = kl[p]  | joy[16*p+1];
      sd[p] = kd[p]  | joy[16*p+2];
      su[p] = ku[p]  | joy[16*p+3];
      f1[p] = kf1[p] | joy[16*p+4];
      f2[p] = kf2[p] | joy[16*p+5];
      st[p] = kst[p] | joy[16*p+6];
      co[p] = kco[p] | joy[16*p+7];
      psrc  = psrc   | joy[16*p+8];
    end
    case (rotate)
      2'd1:    begin ru = sl; rd = sr; rl = sd; rr = su; end
      2'd2:    begin ru = sr; rd = sl; rl = su; rr = sd; end
      2'd3:    begin ru = sd; rd = su; rl = sr; rr = sl; end
      default: begin ru = su; rd = sd; rl = sl; rr = sr; end
    endcase
    for (int p = 0; p < 4; p++) begin
      // Autofire: cycles since the press, high during even half-periods.
      if (f1[p] && !m_f1_prev[p]) m_af_k[p] = 0;
      else if (f1[p])             m_af_k[p] = m_af_k[p] + 1;
      m_f1_prev[p] = f1[p];
      f1o[p] = f1[p];
`ifdef ARCADE_INPUT_AUTOFIRE_EN
      if (autofire[p]) f1o[p] = f1[p] & (((m_af_k[p] / AD) % 2) == 0);
`endif
      // Coin: remaining high cycles of the current pulse.
      if (m_coin_rem[p] > 0)                    m_coin_rem[p] = m_coin_rem[p] - 1;
      else if (co[p] && !m_coin_prev[p])        m_coin_rem[p] = CP;
      m_coin_prev[p] = co[p];
      coo[p] = (m_coin_rem[p] > 0);
    end
    if (psrc && !m_pause_prev) m_pause = !m_pause;
    m_pause_prev = psrc;
    m_out = {ru, rd, rl, rr, f1o, f2, st, coo, m_held[0][8'h46], m_pause};
  endtask

  // ---------------- helpers ----------------
  function automatic logic [33:0] dut_outs();
    return {up, down, left, right, fire1, fire2, start, coin, service, pause};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_sys);
    model_step();
    #1;
  endtask

  task automatic send_key(input logic ext, input logic [7:0] code, input logic pr);
    ps2_key = {~ps2_key[10], pr, ext, code};
  endtask

  typedef struct {
    logic       ext;
    logic [7:0] code;
    logic [3:0] u, d, l, r, f1, f2, st;
    logic       svc;
  } vec_t;

  function automatic vec_t mk(input logic ext, input logic [7:0] code,
                              input logic [3:0] u, d, l, r, f1, f2, st, input logic svc);
    vec_t v;
    v.ext = ext; v.code = code; v.u = u; v.d = d; v.l = l; v.r = r;
    v.f1 = f1; v.f2 = f2; v.st = st; v.svc = svc;
    return v;
  endfunction

  vec_t vecs[$];
  logic [7:0] rnd_codes [0:35] = '{
    8'h75, 8'h72, 8'h6B, 8'h74, 8'h14, 8'h29, 8'h11, 8'h2D, 8'h2B, 8'h23, 8'h34, 8'h1C,
    8'h1B, 8'h43, 8'h42, 8'h3B, 8'h4B, 8'h35, 8'h3C, 8'h70, 8'h71, 8'h16, 8'h1E, 8'h26,
    8'h25, 8'h05, 8'h06, 8'h2E, 8'h36, 8'h3D, 8'h3E, 8'h46, 8'h4D, 8'h1A, 8'h5A, 8'h00};

  initial begin
    int highs, pulses, toggles;
    logic prev;
    ps2_key = '0; joy = '0; rotate = 2'd0; focus_clr = 1'b0;
`ifdef ARCADE_INPUT_AUTOFIRE_EN
    autofire = '0;
`endif
    model_reset();

    // Key map table: one key per row, expected outputs while it is held.
    vecs.push_back(mk(1, 8'h75, 4'h1, 0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 8'h75, 4'h8, 0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(1, 8'h72, 0, 4'h1, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 8'h72, 0, 4'h8, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(1, 8'h6B, 0, 0, 4'h1, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 8'h6B, 0, 0, 4'h8, 0, 0, 0, 0, 0));
    vecs.push_back(mk(1, 8'h74, 0, 0, 0, 4'h1, 0, 0, 0, 0));
    vecs.push_back(mk(0, 8'h74, 0, 0, 0, 4'h8, 0, 0, 0, 0));
    vecs.push_back(mk(0, 8'h14, 0, 0, 0, 0, 4'h1, 0, 0, 0));
    vecs.push_back(mk(1, 8'h14, 0, 0, 0, 0, 4'h1, 0, 0, 0));
    vecs.push_back(mk(0, 8'h29, 0, 0, 0, 0, 4'h1, 0, 0, 0));
    vecs.push_back(mk(1, 8'h11, 0, 0, 0, 0, 0, 4'h1, 0, 0));
    vecs.push_back(mk(0, 8'h2D, 4'h2, 0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 8'h2B, 0, 4'h2, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 8'h23, 0, 0, 4'h2, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 8'h34, 0, 0, 0, 4'h2, 0, 0, 0, 0));
    vecs.push_back(mk(0, 8'h1C, 0, 0, 0, 0, 4'h2, 0, 0, 0));
    vecs.push_back(mk(0, 8'h1B, 0, 0, 0, 0, 0, 4'h2, 0, 0));
    vecs.push_back(mk(0, 8'h43, 4'h4, 0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 8'h42, 0, 4'h4, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 8'h3B, 0, 0, 4'h4, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 8'h4B, 0, 0, 0, 4'h4, 0, 0, 0, 0));
    vecs.push_back(mk(0, 8'h35, 0, 0, 0, 0, 4'h4, 0, 0, 0));
    vecs.push_back(mk(0, 8'h3C, 0, 0, 0, 0, 0, 4'h4, 0, 0));
    vecs.push_back(mk(0, 8'h70, 0, 0, 0, 0, 4'h8, 0, 0, 0));
    vecs.push_back(mk(0, 8'h71, 0, 0, 0, 0, 0, 4'h8, 0, 0));
    vecs.push_back(mk(1, 8'h70, 0, 0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 8'h16, 0, 0, 0, 0, 0, 0, 4'h1, 0));
    vecs.push_back(mk(0, 8'h1E, 0, 0, 0, 0, 0, 0, 4'h2, 0));
    vecs.push_back(mk(0, 8'h26, 0, 0, 0, 0, 0, 0, 4'h4, 0));
    vecs.push_back(mk(0, 8'h25, 0, 0, 0, 0, 0, 0, 4'h8, 0));
    vecs.push_back(mk(0, 8'h05, 0, 0, 0, 0, 0, 0, 4'h1, 0));
    vecs.push_back(mk(0, 8'h06, 0, 0, 0, 0, 0, 0, 4'h2, 0));
    vecs.push_back(mk(0, 8'h46, 0, 0, 0, 0, 0, 0, 0, 1));
    vecs.push_back(mk(0, 8'h1A, 0, 0, 0, 0, 0, 0, 0, 0));

    // Reset state
    repeat (3) @(posedge clk_sys);
    #1;
    check("reset_outputs", 64'(dut_outs()), 64'd0);
    reset_n = 1'b1;

    // Table-driven key map
    foreach (vecs[i]) begin
      send_key(vecs[i].ext, vecs[i].code, 1'b1);
      tick();
      check($sformatf("keymap_press_%0d_%h", i, vecs[i].code),
            64'({up, down, left, right, fire1, fire2, start, service}),
            64'({vecs[i].u, vecs[i].d, vecs[i].l, vecs[i].r, vecs[i].f1, vecs[i].f2, vecs[i].st, vecs[i].svc}));
      send_key(vecs[i].ext, vecs[i].code, 1'b0);
      tick();
      check($sformatf("keymap_release_%0d_%h", i, vecs[i].code),
            64'({up, down, left, right, fire1, fire2, start, service}), 64'd0);
    end

    // Latency: nothing before the edge, result right after it
    send_key(1, 8'h75, 1'b1);
    #1;
    check("latency_before_edge", 64'(up), 64'h0);
    tick();
    check("latency_after_edge", 64'(up), 64'h1);
    send_key(1, 8'h75, 1'b0);
    tick();
    check("latency_release", 64'(up), 64'h0);

    // Rotation with joystick up on P1
    joy[3] = 1'b1; rotate = 2'd1;
    tick();
    check("rot1_up_right", 64'({up, right}), 64'({4'h0, 4'h1}));
    rotate = 2'd3;
    tick();
    check("rot3_down_up", 64'({down, up}), 64'({4'h1, 4'h0}));
    joy = '0; rotate = 2'd0;
    tick();

    // Coin stretch: held key gives one pulse of CP cycles
    send_key(0, 8'h2E, 1'b1);
    highs = 0; pulses = 0; prev = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (coin[0]) highs++;
      if (coin[0] && !prev) pulses++;
      prev = coin[0];
    end
    check("coin_hold_high_cycles", 64'(highs), 64'(CP));
    check("coin_hold_pulses", 64'(pulses), 64'd1);
    send_key(0, 8'h2E, 1'b0);
    repeat (3) tick();
    // Release and re-press inside a running pulse
    send_key(0, 8'h2E, 1'b1);
    highs = 0; pulses = 0; prev = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (i == 2) send_key(0, 8'h2E, 1'b0);
      if (i == 3) send_key(0, 8'h2E, 1'b1);
      tick();
      if (coin[0]) highs++;
      if (coin[0] && !prev) pulses++;
      prev = coin[0];
    end
    check("coin_repress_high_cycles", 64'(highs), 64'(CP));
    check("coin_repress_pulses", 64'(pulses), 64'd1);
    send_key(0, 8'h2E, 1'b0);
    tick();

    // Pause latch via key 4D, then a held joystick pause bit
    for (int n = 0; n < 2; n++) begin
      send_key(0, 8'h4D, 1'b1);
      tick();
      send_key(0, 8'h4D, 1'b0);
      tick();
      check($sformatf("pause_key_%0d", n), 64'(pause), (n == 0) ? 64'd1 : 64'd0);
    end
    joy[16+8] = 1'b1;
    toggles = 0; prev = pause;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (pause != prev) toggles++;
      prev = pause;
    end
    check("pause_joy_hold_toggles", 64'(toggles), 64'd1);
    check("pause_joy_hold_value", 64'(pause), 64'd1);
    joy = '0;
    tick();

    // focus_clr versus a coincident press, joystick path unaffected
    send_key(0, 8'h29, 1'b1);
    tick();
    check("space_fire1", 64'(fire1), 64'h1);
    focus_clr = 1'b1;
    send_key(0, 8'h2D, 1'b1);
    tick();
    check("focus_clr_fire1", 64'(fire1), 64'h0);
    check("focus_clr_up", 64'(up), 64'h0);
    focus_clr = 1'b0;
    tick();
    check("focus_clr_event_consumed", 64'(up), 64'h0);
    joy[4] = 1'b1;
    tick();
    focus_clr = 1'b1;
    tick();
    check("focus_clr_joy_fire1", 64'(fire1), 64'h1);
    focus_clr = 1'b0; joy = '0;
    tick();
    check("fire1_idle", 64'(fire1), 64'h0);

`ifdef ARCADE_INPUT_AUTOFIRE_EN
    // Autofire pattern: AD cycles on, AD cycles off
    autofire = 4'b0001;
    joy[4] = 1'b1;
    for (int i = 0; i < 16; i++) begin
      tick();
      check($sformatf("autofire_cycle_%0d", i), 64'(fire1[0]), ((i % (2*AD)) < AD) ? 64'd1 : 64'd0);
    end
    joy = '0; autofire = '0;
    tick();
`endif

    // Randomised traffic against the model
    for (int cyc = 0; cyc < 2000; cyc++) begin
      if ($urandom_range(0, 2) == 0)
        send_key(1'($urandom_range(0, 1)), rnd_codes[$urandom_range(0, 35)], 1'($urandom_range(0, 1)));
      if ($urandom_range(0, 7) == 0) begin
        int p, b;
        p = $urandom_range(0, 3);
        b = $urandom_range(0, 8);
        joy[16*p+b] = ~joy[16*p+b];
      end
      if ($urandom_range(0, 63) == 0) rotate = 2'($urandom_range(0, 3));
      focus_clr = ($urandom_range(0, 39) == 0);
`ifdef ARCADE_INPUT_AUTOFIRE_EN
      if ($urandom_range(0, 63) == 0) autofire = 4'($urandom_range(0, 15));
`endif
      tick();
      check($sformatf("random_cycle_%0d", cyc), 64'(dut_outs()), 64'(m_out));
    end

    // Async reset in the middle of a coin pulse
    ps2_key[9] = 1'b0; joy = '0; focus_clr = 1'b0; rotate = 2'd0;
    send_key(0, 8'h00, 1'b0);
    repeat (12) tick();
    joy[7] = 1'b1;
    tick();
    tick();
    check("coin_before_reset", 64'(coin[0]), 64'd1);
    #2;
    reset_n = 1'b0;
    #1;
    check("async_reset_outputs", 64'(dut_outs()), 64'd0);
    joy = '0;
    repeat (2) @(posedge clk_sys);
    #1;
    reset_n = 1'b1;
    model_reset();
    tick();
    tick();
    check("after_reset_idle", 64'(dut_outs()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
